// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Control sequencer for a small accumulator machine. A six-step one-hot ring
// (T1..T6) advances once per clock. T1-T3 fetch the instruction and T4-T6
// execute it. The control word is a purely combinational (Moore) decode of
// the registered ring state, the halt flag and the opcode.
//
// Ports
//   clk        in   single clock, rising edge active
//   rst        in   synchronous, active-high reset: forces T1 and clears halt
//   ir_opcode  in   [3:0] upper nibble of the instruction register
//   t_state    out  [5:0] one-hot ring state, bit0 = T1 ... bit5 = T6
//   cp ep lm   out  PC increment, PC-to-bus, load MAR
//   ce li ei   out  RAM-to-bus, load IR, IR-operand-to-bus
//   la ea lb   out  load accumulator, accumulator-to-bus, load B
//   lo         out  load output register
//   alu1 alu0  out  ALU function select
//   add_sub    out  ALU add (0) / subtract (1)
//   xor_not    out  ALU xor (0) / not (1)
//   alu_out    out  ALU-to-bus enable
//   halt       out  machine halted; only rst clears it
// -----------------------------------------------------------------------------
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_opcode,
  output logic [5:0] t_state,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       lo,
  output logic       alu1,
  output logic       alu0,
  output logic       add_sub,
  output logic       xor_not,
  output logic       alu_out,
  output logic       halt
);

  // Ring states
  localparam logic [5:0] StT1 = 6'b000001;
  localparam logic [5:0] StT2 = 6'b000010;
  localparam logic [5:0] StT3 = 6'b000100;
  localparam logic [5:0] StT4 = 6'b001000;
  localparam logic [5:0] StT5 = 6'b010000;
  localparam logic [5:0] StT6 = 6'b100000;

  // Opcode encoding
  localparam logic [3:0] OpLda = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0100;
  localparam logic [3:0] OpXor = 4'b0101;
  localparam logic [3:0] OpNot = 4'b0110;
  localparam logic [3:0] OpOut = 4'b1110;
  localparam logic [3:0] OpHlt = 4'b1111;

  logic [5:0] t_state_q, t_state_d;
  logic       halt_q, halt_d;
  logic       ring_valid;

  // ---------------------------------------------------------------------------
  // Opcode classification
  // ---------------------------------------------------------------------------
  logic is_lda, is_add, is_sub, is_and, is_or, is_xor, is_not, is_out, is_hlt;
  logic is_alu2;   // two-operand ALU ops: memory operand goes through B
  logic is_mem;    // ops that fetch an operand from RAM in T4/T5

  always_comb begin
    is_lda  = (ir_opcode == OpLda);
    is_add  = (ir_opcode == OpAdd);
    is_sub  = (ir_opcode == OpSub);
    is_and  = (ir_opcode == OpAnd);
    is_or   = (ir_opcode == OpOr);
    is_xor  = (ir_opcode == OpXor);
    is_not  = (ir_opcode == OpNot);
    is_out  = (ir_opcode == OpOut);
    is_hlt  = (ir_opcode == OpHlt);
    is_alu2 = is_add | is_sub | is_and | is_or | is_xor;
    is_mem  = is_lda | is_alu2;
  end

  // ---------------------------------------------------------------------------
  // Ring and halt next state
  // ---------------------------------------------------------------------------
  // A corrupted (non-one-hot) ring would otherwise stall or drive conflicting
  // controls forever; it re-enters at T1 instead.
  assign ring_valid = (t_state_q != 6'b0) && ((t_state_q & (t_state_q - 6'd1)) == 6'b0);

  always_comb begin
    t_state_d = t_state_q;
    halt_d    = halt_q;
    if (!halt_q) begin
      if ((t_state_q == StT4) && is_hlt) begin
        // Freeze on T4; the ring does not advance past a halt.
        halt_d = 1'b1;
      end else if (ring_valid) begin
        t_state_d = {t_state_q[4:0], t_state_q[5]};
      end else begin
        t_state_d = StT1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_q <= StT1;
      halt_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halt_q    <= halt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  // Step strobes are qualified by !halt so every control except halt drops to
  // zero while halted, independent of the opcode.
  logic t1, t2, t3, t4, t5, t6, t_exec;

  always_comb begin
    t1     = !halt_q && (t_state_q == StT1);
    t2     = !halt_q && (t_state_q == StT2);
    t3     = !halt_q && (t_state_q == StT3);
    t4     = !halt_q && (t_state_q == StT4);
    t5     = !halt_q && (t_state_q == StT5);
    t6     = !halt_q && (t_state_q == StT6);
    t_exec = t4 | t5 | t6;
  end

  always_comb begin
    // Fetch plus operand fetch
    ep = t1;
    cp = t2;
    li = t3;
    lm = t1 | (t4 & is_mem);
    ce = t3 | (t5 & is_mem);
    ei = t4 & is_mem;

    // Register loads and accumulator output
    la = (t5 & is_lda) | (t6 & is_alu2) | (t4 & is_not);
    lb = t5 & is_alu2;
    ea = t4 & is_out;
    lo = t4 & is_out;

    // ALU selects stay stable for the whole of T4-T6 on two-operand ops so the
    // ALU result has settled before alu_out opens in T6. NOT is single-step.
    alu1    = (t_exec & (is_or  | is_xor)) | (t4 & is_not);
    alu0    = (t_exec & (is_and | is_xor)) | (t4 & is_not);
    add_sub = t_exec & is_sub;
    xor_not = t4 & is_not;
    alu_out = (t6 & is_alu2) | (t4 & is_not);

    t_state = t_state_q;
    halt    = halt_q;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench: directed sequences followed by randomized opcodes and
// resets, every cycle compared against a step-counter reference model.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ir_opcode;
  logic [5:0] t_state;
  logic cp, ep, lm, ce, li, ei, la, ea, lb, lo;
  logic alu1, alu0, add_sub, xor_not, alu_out, halt;

  control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .ir_opcode (ir_opcode),
    .t_state   (t_state),
    .cp        (cp),
    .ep        (ep),
    .lm        (lm),
    .ce        (ce),
    .li        (li),
    .ei        (ei),
    .la        (la),
    .ea        (ea),
    .lb        (lb),
    .lo        (lo),
    .alu1      (alu1),
    .alu0      (alu0),
    .add_sub   (add_sub),
    .xor_not   (xor_not),
    .alu_out   (alu_out),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  // Control word bit masks, in the order of the observed vector below.
  localparam logic [15:0] MCp   = 16'h8000;
  localparam logic [15:0] MEp   = 16'h4000;
  localparam logic [15:0] MLm   = 16'h2000;
  localparam logic [15:0] MCe   = 16'h1000;
  localparam logic [15:0] MLi   = 16'h0800;
  localparam logic [15:0] MEi   = 16'h0400;
  localparam logic [15:0] MLa   = 16'h0200;
  localparam logic [15:0] MEa   = 16'h0100;
  localparam logic [15:0] MLb   = 16'h0080;
  localparam logic [15:0] MLo   = 16'h0040;
  localparam logic [15:0] MA1   = 16'h0020;
  localparam logic [15:0] MA0   = 16'h0010;
  localparam logic [15:0] MSub  = 16'h0008;
  localparam logic [15:0] MNot  = 16'h0004;
  localparam logic [15:0] MAOut = 16'h0002;
  localparam logic [15:0] MHalt = 16'h0001;

  logic [15:0] ctrl_obs;
  logic [4:0]  bus_obs;
  assign ctrl_obs = {cp, ep, lm, ce, li, ei, la, ea, lb, lo,
                     alu1, alu0, add_sub, xor_not, alu_out, halt};
  assign bus_obs  = {ep, ce, ei, ea, alu_out};

  int checks   = 0;
  int failures = 0;

  // Reference model: instruction step 0..5 (T1..T6) and a halted flag.
  int step      = 0;
  bit m_halted  = 1'b0;
  int halt_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h step=%0d op=%h t=%0t", tag, got, exp, step, ir_opcode,
               $time);
    end
  endtask

  // Expected controls straight from the instruction table.
  function automatic logic [15:0] exp_ctrl(input int s, input logic [3:0] op, input bit hlt);
    logic [15:0] sel;
    if (hlt) return MHalt;
    case (s)
      0: return MEp | MLm;
      1: return MCp;
      2: return MCe | MLi;
      default: ;
    endcase
    case (op)
      4'h0: begin
        if (s == 3) return MEi | MLm;
        if (s == 4) return MCe | MLa;
        return 16'h0;
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        case (op)
          4'h1:    sel = 16'h0;
          4'h2:    sel = MSub;
          4'h3:    sel = MA0;
          4'h4:    sel = MA1;
          default: sel = MA1 | MA0;
        endcase
        if (s == 3) return MEi | MLm | sel;
        if (s == 4) return MCe | MLb | sel;
        return MAOut | MLa | sel;
      end
      4'h6:    return (s == 3) ? (MA1 | MA0 | MNot | MAOut | MLa) : 16'h0;
      4'hE:    return (s == 3) ? (MEa | MLo) : 16'h0;
      default: return 16'h0;
    endcase
  endfunction

  // One clock: drive inputs, advance the model on the edge, check mid-cycle.
  task automatic tick(input logic r, input logic [3:0] op);
    rst       = r;
    ir_opcode = op;
    @(posedge clk);
    if (r) begin
      step     = 0;
      m_halted = 1'b0;
      halt_cnt = 0;
    end else if (m_halted) begin
      halt_cnt++;
    end else if (step == 3 && op == 4'hF) begin
      m_halted = 1'b1;
    end else begin
      step = (step + 1) % 6;
    end
    @(negedge clk);
    check("t_state", 32'(t_state), 32'(6'b1 << step));
    check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(step, op, m_halted)));
    check("bus_single", 32'($countones(bus_obs) <= 1), 32'd1);
  endtask

  initial begin
    logic [3:0] op;

    // Reset, then LDA for two instructions.
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    for (int i = 0; i < 12; i++) tick(1'b0, 4'h0);

    // SUB then NOT.
    for (int i = 0; i < 6; i++) tick(1'b0, 4'h2);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'h6);

    // HLT: halts on the T4 edge and stays frozen with a changing opcode.
    for (int i = 0; i < 4; i++) tick(1'b0, 4'hF);
    for (int i = 0; i < 20; i++) tick(1'b0, 4'($urandom_range(0, 15)));
    check("halted_hold", 32'({halt, t_state}), 32'({1'b1, 6'b001000}));
    tick(1'b1, 4'h0);
    check("halt_clear", 32'({halt, t_state}), 32'({1'b0, 6'b000001}));

    // Reset during T5 of ADD abandons the instruction.
    for (int i = 0; i < 4; i++) tick(1'b0, 4'h1);
    check("add_t5", 32'(t_state), 32'(6'b010000));
    tick(1'b1, 4'h1);
    for (int i = 0; i < 6; i++) tick(1'b0, 4'h1);

    // Sweep every opcode through a full instruction.
    for (int o = 0; o < 16; o++) begin
      tick(1'b1, 4'(o));
      for (int i = 0; i < 6; i++) tick(1'b0, 4'(o));
    end

    // Randomized opcodes and resets.
    tick(1'b1, 4'h0);
    op = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halted) begin
        op = 4'($urandom_range(0, 15));
        tick(halt_cnt >= 20, op);
      end else begin
        if (step == 0) op = 4'($urandom_range(0, 15));
        tick($urandom_range(0, 49) == 0, op);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
